// File: rtl/mod461_residue_accumulator.sv
// Streaming modulo-MODULUS accumulator for per-chunk residues of a wide operand.
// One residue beat per cycle in ACCUM; the final residue is held in HOLD until taken downstream.
module mod461_residue_accumulator #(
   parameter int MODULUS    = 461,
   parameter int NUM_CHUNKS = 84,
   parameter int CNT_W      = 7
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   output logic       in_ready,
   input  logic [8:0] in_res,
   input  logic       in_last,
   output logic       out_valid,
   input  logic       out_ready,
   output logic [8:0] out_res,
   output logic       out_err
);

   // Stream handshakes: a transfer happens on a rising edge where valid and ready
   // are both high; a source holding valid keeps its payload stable until then.

   typedef enum logic {ACCUM, HOLD} state_t;

   localparam logic [9:0] MOD_W = MODULUS[9:0];
   localparam logic [CNT_W:0] TARGET = NUM_CHUNKS[CNT_W:0];
   localparam int SAT_I = NUM_CHUNKS + 1;
   localparam logic [CNT_W-1:0] SAT = SAT_I[CNT_W-1:0];

   state_t state, next_state;

   logic [8:0]       acc;
   logic [CNT_W-1:0] cnt;
   logic             rng_err;

   logic             accept;
   logic             over;
   logic [8:0]       r;
   logic [9:0]       s;
   logic [8:0]       acc_next;
   logic [CNT_W:0]   cnt_inc;
   logic [CNT_W-1:0] cnt_next;
   logic             len_err;

   // Readiness is a decode of the registered state, forced low while reset is held.
   assign in_ready  = (state == ACCUM) && !rst;
   assign out_valid = (state == HOLD);
   assign accept    = in_valid && in_ready;

   always_comb begin
      over     = ({1'b0, in_res} >= MOD_W);
      r        = over ? (in_res - MOD_W[8:0]) : in_res;
      s        = {1'b0, acc} + {1'b0, r};
      acc_next = (s >= MOD_W) ? 9'(s - MOD_W) : s[8:0];
      cnt_inc  = {1'b0, cnt} + {{CNT_W{1'b0}}, 1'b1};
      cnt_next = (cnt == SAT) ? cnt : cnt_inc[CNT_W-1:0];
      len_err  = (cnt_inc != TARGET);
   end

   always_comb begin
      next_state = state;
      case (state)
         ACCUM: if (accept && in_last) next_state = HOLD;
         HOLD:  if (out_ready) next_state = ACCUM;
         default: next_state = ACCUM;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) state <= ACCUM;
      else     state <= next_state;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         acc     <= '0;
         cnt     <= '0;
         rng_err <= 1'b0;
         out_res <= '0;
         out_err <= 1'b0;
      end else if (accept) begin
         if (in_last) begin
            // The result and the error flag both include the closing beat.
            out_res <= acc_next;
            out_err <= rng_err | over | len_err;
            acc     <= '0;
            cnt     <= '0;
            rng_err <= 1'b0;
         end else begin
            acc     <= acc_next;
            cnt     <= cnt_next;
            rng_err <= rng_err | over;
         end
      end
   end

endmodule

// File: tb/tb_mod461_residue_accumulator.sv
// Directed bench for mod461_residue_accumulator: hand-computed residues checked through a scoreboard.
module tb_mod461_residue_accumulator;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid, in_ready, in_last, out_valid, out_ready, out_err;
   logic [8:0] in_res, out_res;

   logic       one_in_valid, one_in_ready, one_in_last, one_out_valid, one_out_ready, one_out_err;
   logic [8:0] one_in_res, one_out_res;

   int         checks = 0;
   int         errors = 0;
   logic [9:0] exp_q[$];
   int         vals[];

   always #5 clk = ~clk;

   mod461_residue_accumulator dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready), .in_res(in_res), .in_last(in_last),
      .out_valid(out_valid), .out_ready(out_ready), .out_res(out_res), .out_err(out_err)
   );

   mod461_residue_accumulator #(.MODULUS(461), .NUM_CHUNKS(1), .CNT_W(2)) u_one (
      .clk(clk), .rst(rst),
      .in_valid(one_in_valid), .in_ready(one_in_ready), .in_res(one_in_res), .in_last(one_in_last),
      .out_valid(one_out_valid), .out_ready(one_out_ready), .out_res(one_out_res), .out_err(one_out_err)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0d expected %0d", tag, got, exp);
      end
   endtask

   // Called at a falling edge; returns at the falling edge after the beat was taken.
   task automatic send_beat(input logic [8:0] res, input logic last);
      int guard = 0;
      in_valid = 1'b1;
      in_res   = res;
      in_last  = last;
      while (!in_ready && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      if (!in_ready) check("in_ready_wait", {31'd0, in_ready}, 1);
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      in_last  = 1'b0;
   endtask

   task automatic send_op(input int n, input logic [8:0] exp_res, input logic exp_err, input bit watch_acc);
      for (int k = 1; k <= n; k++) begin
         send_beat(9'(vals[k-1]), k == n);
         if (watch_acc && k < n) check("acc_wrap", {23'd0, dut.acc}, 461 - k);
      end
      exp_q.push_back({exp_err, exp_res});
   endtask

   task automatic get_result(input string tag);
      int guard = 0;
      logic [9:0] e;
      while (!out_valid && guard < 50) begin
         @(negedge clk);
         guard++;
      end
      check({tag, "_valid"}, {31'd0, out_valid}, 1);
      e = exp_q.pop_front();
      check({tag, "_res"}, {23'd0, out_res}, {23'd0, e[8:0]});
      check({tag, "_err"}, {31'd0, out_err}, {31'd0, e[9]});
      if (out_ready) begin
         @(negedge clk);
         check({tag, "_drop"}, {31'd0, out_valid}, 0);
         check({tag, "_gap"}, {31'd0, in_ready}, 1);
      end
   endtask

   task automatic fill(input int n, input int v);
      vals = new[n];
      foreach (vals[i]) vals[i] = v;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1; in_valid = 1'b0; in_res = '0; in_last = 1'b0; out_ready = 1'b1;
      one_in_valid = 1'b0; one_in_res = '0; one_in_last = 1'b0; one_out_ready = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_in_ready", {31'd0, in_ready}, 0);
      check("rst_out_valid", {31'd0, out_valid}, 0);
      check("rst_out_res", {23'd0, out_res}, 0);
      check("rst_out_err", {31'd0, out_err}, 0);
      rst = 1'b0;
      @(negedge clk);
      check("post_rst_in_ready", {31'd0, in_ready}, 1);

      one_in_valid = 1'b1; one_in_res = 9'd100; one_in_last = 1'b1;
      @(posedge clk);
      @(negedge clk);
      one_in_valid = 1'b0; one_in_last = 1'b0;
      check("one_valid", {31'd0, one_out_valid}, 1);
      check("one_res", {23'd0, one_out_res}, 100);
      check("one_err", {31'd0, one_out_err}, 0);

      fill(84, 460);
      send_op(84, 9'd377, 1'b0, 1'b1);
      get_result("all460");

      vals = new[84];
      foreach (vals[i]) vals[i] = (i % 2 == 0) ? 230 : 231;
      send_op(84, 9'd0, 1'b0, 1'b0);
      get_result("alt");

      fill(84, 0);
      vals[9] = 500;
      send_op(84, 9'd39, 1'b1, 1'b0);
      get_result("range");

      fill(83, 1);
      send_op(83, 9'd83, 1'b1, 1'b0);
      get_result("short83");

      fill(90, 10);
      send_op(90, 9'd439, 1'b1, 1'b0);
      get_result("long90");

      out_ready = 1'b0;
      fill(84, 5);
      send_op(84, 9'd420, 1'b0, 1'b0);
      for (int c = 0; c < 5; c++) begin
         check("bp_valid", {31'd0, out_valid}, 1);
         check("bp_res", {23'd0, out_res}, 420);
         check("bp_in_ready", {31'd0, in_ready}, 0);
         @(negedge clk);
      end
      out_ready = 1'b1;
      get_result("bp");

      for (int k = 0; k < 40; k++) send_beat(9'd7, 1'b0);
      rst = 1'b1;
      @(negedge clk);
      check("mid_rst_in_ready", {31'd0, in_ready}, 0);
      check("mid_rst_out_valid", {31'd0, out_valid}, 0);
      rst = 1'b0;
      @(negedge clk);
      fill(84, 1);
      send_op(84, 9'd84, 1'b0, 1'b0);
      get_result("after_rst");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mod461_residue_accumulator.md
# mod461_residue_accumulator

Sequential consumer of the per-chunk residue lookup tables in the mod-461, 500-bit binary-to-residue converter. Each table maps one 6-bit slice of the operand to a 9-bit residue (slice · 2^(6k) mod 461). This block accepts those residues one per beat over a valid/ready stream and accumulates them modulo 461. It emits the final residue of the full 500-bit operand on an output valid/ready handshake, and flags length and range errors.

## Interface
- MODULUS, 461, reduction modulus; must satisfy 256 < MODULUS < 512 (9-bit residues).
- NUM_CHUNKS, 84, number of residue beats per operand (ceil(500/6)).
- CNT_W, 7, counter width; ceil(log2(NUM_CHUNKS+1)).
- clk  input  1  rising-edge clock; one clock domain.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  residue beat present.
- in_ready  output  1  block accepts the beat this cycle.
- in_res  input  9  chunk residue, nominally < MODULUS.
- in_last  input  1  marks the final beat of an operand.
- out_valid  output  1  result available.
- out_ready  input  1  downstream accepts the result.
- out_res  output  9  operand residue, always < MODULUS.
- out_err  output  1  operand had a length or range error; qualified by out_valid.

## Operation
- State machine states: ACCUM and HOLD. Reset enters ACCUM with acc = 0 and cnt = 0.
- ACCUM:
  - in_ready = 1.
  - A beat is accepted when in_valid & in_ready.
  - Input normalisation: r = (in_res >= MODULUS) ? in_res - MODULUS : in_res. Because in_res ≤ 511, a single subtract always yields r < MODULUS.
  - If in_res >= MODULUS, set sticky rng_err.
  - Modular add: s = acc + r, computed at 10 bits. acc_next = (s >= MODULUS) ? s - MODULUS : s.
  - cnt increments on each accepted beat and saturates at NUM_CHUNKS+1.
- Beat accepted with in_last = 1:
  - out_res ← acc_next.
  - out_err ← rng_err | (cnt+1 != NUM_CHUNKS), where the range error includes the current beat.
  - out_valid ← 1. State → HOLD.
  - acc, cnt and rng_err clear to 0 for the next operand.
- Beat count reaching NUM_CHUNKS without in_last does not terminate the operand. Accumulation continues until in_last arrives, and the result is then flagged out_err = 1 because the count mismatches.
- HOLD:
  - in_ready = 0.
  - out_valid, out_res and out_err are held stable until out_valid & out_ready.
  - On the handshake: out_valid ← 0, state → ACCUM.
- Result is unsigned; out_res ∈ [0, MODULUS-1] in all cases.

## Timing
- Reset values: in_ready = 0 during the reset cycle, then 1. out_valid = 0, out_res = 0, out_err = 0. Internal acc = 0, cnt = 0, rng_err = 0.
- in_ready is a registered state decode (ACCUM), not combinational from out_ready.
- Throughput: one beat per cycle in ACCUM.
- Latency: out_valid rises on the clock edge that accepts the in_last beat, i.e. the result is visible in the following cycle.
- Minimum operand-to-operand gap: 1 cycle of in_ready = 0, the HOLD cycle with immediate out_ready.
- out_ready high while out_valid = 1: handshake completes on that edge; in_ready = 1 in the next cycle.
- out_ready may be asserted before out_valid. No combinational path from out_ready to out_valid.
- rst asserted mid-operand or in HOLD: on the next edge all state returns to reset values. Any partial sum or undelivered result is discarded.
- in_valid held while in_ready = 0: no beat consumed; the source must hold in_res and in_last stable.

## Test plan
- Single beat, in_res = 100, in_last = 1 (NUM_CHUNKS overridden to 1) -> next cycle out_valid = 1, out_res = 100, out_err = 0.
- 84 beats of in_res = 460, last on beat 84 -> out_res = (84·460) mod 461 = 377, out_err = 0. Also check the wrap subtract on every beat after the first.
- 84 beats alternating 230 / 231 -> each pair sums to exactly 461 ≡ 0. Final out_res = 0, exercising the s == MODULUS boundary.
- Beat with in_res = 500 inside an 84-beat operand of zeros -> out_res = 39, out_err = 1.
- in_last on beat 83 -> out_err = 1. in_last on beat 90 -> out_err = 1, out_res equals the modular sum of all 90 beats.
- Back-pressure and reset: hold out_ready = 0 for 5 cycles; out_res stays stable and in_ready = 0. Then assert rst mid-way through the next operand; after reset, a fresh 84-beat operand of in_res = 1 gives out_res = 84 with no carry-over from before reset.
